// File: rtl/aes256_key_expand_if.sv
// Handshake/bus bundle between the AES-256 key-schedule engine and its controller/consumer.
interface aes256_key_expand_if;
  logic         key_load;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         done;

  modport master (
    output key_load, key_in,
    input  busy, rk_valid, rk_idx, rk, done
  );

  modport slave (
    input  key_load, key_in,
    output busy, rk_valid, rk_idx, rk, done
  );
endinterface

// File: rtl/aes256_key_expand.sv
// AES-256 key schedule: one expanded word per clock through an 8-word sliding window,
// round keys emitted every 4 cycles. SubWord uses four parallel combinational S-boxes.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so entry a starts at bit (255-a)*8.
  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes256_key_expand (
  input  logic                  clk,
  input  logic                  rst_n,
  aes256_key_expand_if.slave    kif
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [0:7][31:0]    win_q, win_d;
  logic [0:2][31:0]    acc_q, acc_d;
  logic [5:0]          i_q, i_d;
  logic                busy_q, busy_d;
  logic                rk_valid_q, rk_valid_d;
  logic                done_q, done_d;
  logic [3:0]          rk_idx_q, rk_idx_d;
  logic [127:0]        rk_q, rk_d;

  logic [6:0]          j;
  logic [31:0]         rot_word;
  logic [31:0]         sub_in;
  logic [31:0]         sub_out;
  logic [7:0]          rcon;
  logic [31:0]         t_word;
  logic [31:0]         new_word;

  assign j        = {1'b0, i_q} + 7'd8;
  assign rot_word = {win_q[7][23:0], win_q[7][31:24]};
  assign sub_in   = (j[2:0] == 3'd0) ? rot_word : win_q[7];

  for (genvar b = 0; b < 4; b++) begin : g_sub
    sbox u_sbox (
      .a (sub_in[8*b +: 8]),
      .y (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    rcon = 8'h00;
    case (j[6:3])
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    t_word = win_q[7];
    if (j[2:0] == 3'd0) begin
      t_word = sub_out ^ {rcon, 24'h000000};
    end else if (j[2:0] == 3'd4) begin
      t_word = sub_out;
    end
    new_word = (j <= 7'd59) ? (win_q[0] ^ t_word) : '0;
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    acc_d      = acc_q;
    i_d        = i_q;
    busy_d     = busy_q;
    rk_valid_d = 1'b0;
    done_d     = 1'b0;
    rk_idx_d   = rk_idx_q;
    rk_d       = rk_q;

    case (state_q)
      IDLE: begin
        if (kif.key_load) begin
          state_d = RUN;
          busy_d  = 1'b1;
          win_d   = kif.key_in;
          acc_d   = '0;
          i_d     = '0;
        end
      end
      RUN: begin
        win_d = {win_q[1:7], new_word};
        acc_d = {acc_q[1:2], win_q[0]};
        i_d   = i_q + 6'd1;
        if (i_q[1:0] == 2'b11) begin
          rk_valid_d = 1'b1;
          rk_d       = {acc_q, win_q[0]};
          rk_idx_d   = i_q[5:2];
        end
        if (i_q == 6'd59) begin
          done_d = 1'b1;
          i_d    = '0;
          // A load on the finishing edge chains straight into the next key.
          if (kif.key_load) begin
            win_d = kif.key_in;
            acc_d = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= '0;
      acc_q      <= '0;
      i_q        <= '0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      rk_idx_q   <= '0;
      rk_q       <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      i_q        <= i_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
      rk_idx_q   <= rk_idx_d;
      rk_q       <= rk_d;
    end
  end

  assign kif.busy     = busy_q;
  assign kif.rk_valid = rk_valid_q;
  assign kif.done     = done_q;
  assign kif.rk_idx   = rk_idx_q;
  assign kif.rk       = rk_q;
endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed bench for aes256_key_expand: FIPS-197 key vectors, pulse timing,
// ignored mid-run loads, asynchronous reset, and back-to-back loads.
module tb_aes256_key_expand;
  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K1_RK2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] K1_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  typedef struct {
    string        name;
    logic [255:0] key;
    int           idx;
    logic [127:0] mask;
    logic [127:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes256_key_expand_if kif();

  aes256_key_expand dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] rec_rk [15];
  int           rec_edge [15];
  int           n_pulse, done_edge, busy_err, seq_err, sec_edge;
  logic         busy_at60;
  logic [127:0] sec_rk0;
  vec_t         vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Loads k before the next edge (E0) and records every pulse up to E66.
  // inj>0 drives a second load of k2 sampled at edge E(inj).
  task automatic run_key(input logic [255:0] k, input int inj, input logic [255:0] k2);
    n_pulse = 0; done_edge = -1; busy_err = 0; seq_err = 0;
    sec_edge = -1; sec_rk0 = '0; busy_at60 = 1'bx;
    for (int r = 0; r < 15; r++) begin
      rec_rk[r]   = '0;
      rec_edge[r] = -1;
    end
    kif.key_in   = k;
    kif.key_load = 1'b1;
    @(posedge clk); #1;
    kif.key_load = 1'b0;
    for (int e = 1; e <= 66; e++) begin
      if (e == inj) begin
        kif.key_in   = k2;
        kif.key_load = 1'b1;
      end
      @(posedge clk); #1;
      kif.key_load = 1'b0;
      if (e <= 60) begin
        if (e < 60 && kif.busy !== 1'b1) busy_err++;
        if (kif.rk_valid === 1'b1) begin
          if (kif.rk_idx !== n_pulse[3:0]) seq_err++;
          rec_rk[kif.rk_idx]   = kif.rk;
          rec_edge[kif.rk_idx] = e;
          n_pulse++;
          if (kif.done === 1'b1) done_edge = e;
        end else if (kif.done !== 1'b0) begin
          busy_err++;
        end
        if (e == 60) busy_at60 = kif.busy;
      end else if (kif.rk_valid === 1'b1 && sec_edge < 0) begin
        sec_edge = e;
        sec_rk0  = kif.rk;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int spacing_err;
    int idle_err;

    vecs[0] = '{"k1_rk0",  K1, 0,  '1, K1[255:128]};
    vecs[1] = '{"k1_rk1",  K1, 1,  '1, K1[127:0]};
    vecs[2] = '{"k1_rk2",  K1, 2,  '1, K1_RK2};
    vecs[3] = '{"k1_rk14", K1, 14, '1, K1_RK14};
    vecs[4] = '{"k2_rk0",  K2, 0,  '1, K2[255:128]};
    vecs[5] = '{"k2_rk1",  K2, 1,  '1, K2[127:0]};
    vecs[6] = '{"k2_w8",   K2, 2,  {32'hffffffff, 96'h0}, {32'h9ba35411, 96'h0}};
    vecs[7] = '{"k2_w59",  K2, 14, {96'h0, 32'hffffffff}, {96'h0, 32'h706c631e}};

    kif.key_load = 1'b0;
    kif.key_in   = '0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",     {127'b0, kif.busy},     '0);
    check("rst_rk_valid", {127'b0, kif.rk_valid}, '0);
    check("rst_done",     {127'b0, kif.done},     '0);
    check("rst_rk_idx",   {124'b0, kif.rk_idx},   '0);
    check("rst_rk",       kif.rk,                 '0);

    @(negedge clk);
    rst_n = 1'b1;
    idle_err = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (kif.busy !== 1'b0 || kif.rk_valid !== 1'b0 || kif.done !== 1'b0 ||
          kif.rk_idx !== 4'd0 || kif.rk !== 128'd0) idle_err++;
    end
    check("idle_100_cycles", idle_err, 0);

    for (int v = 0; v < 8; v++) begin
      run_key(vecs[v].key, 0, '0);
      check(vecs[v].name, rec_rk[vecs[v].idx] & vecs[v].mask, vecs[v].exp);
    end

    // Structural checks on the last (K2) expansion.
    spacing_err = 0;
    for (int r = 0; r < 15; r++) begin
      if (rec_edge[r] != 4 * r + 4) spacing_err++;
    end
    check("pulse_count",   n_pulse, 15);
    check("pulse_spacing", spacing_err, 0);
    check("idx_sequence",  seq_err, 0);
    check("busy_during",   busy_err, 0);
    check("done_edge",     done_edge, 60);
    check("busy_at_e60",   {127'b0, busy_at60}, '0);

    // Load during RUN must be ignored.
    run_key(K1, 20, K2);
    check("ign_rk0",      rec_rk[0],  K1[255:128]);
    check("ign_rk2",      rec_rk[2],  K1_RK2);
    check("ign_rk14",     rec_rk[14], K1_RK14);
    check("ign_busy",     busy_err, 0);
    check("ign_done",     done_edge, 60);
    check("ign_no_restart", sec_edge, -1);

    // Asynchronous reset mid-expansion.
    kif.key_in   = K1;
    kif.key_load = 1'b1;
    @(posedge clk); #1;
    kif.key_load = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    check("pre_rst_rk_nonzero", {127'b0, (kif.rk != '0)}, 128'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",     {127'b0, kif.busy},     '0);
    check("midrst_rk_valid", {127'b0, kif.rk_valid}, '0);
    check("midrst_rk",       kif.rk,                 '0);
    check("midrst_rk_idx",   {124'b0, kif.rk_idx},   '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_key(K1, 0, '0);
    check("postrst_rk0",  rec_rk[0],  K1[255:128]);
    check("postrst_rk2",  rec_rk[2],  K1_RK2);
    check("postrst_rk14", rec_rk[14], K1_RK14);
    check("postrst_rk0_edge", rec_edge[0], 4);

    // Back-to-back: second load sampled at E60.
    run_key(K1, 60, K2);
    check("b2b_first_rk14", rec_rk[14], K1_RK14);
    check("b2b_done_edge",  done_edge, 60);
    check("b2b_second_edge", sec_edge, 64);
    check("b2b_second_rk0",  sec_rk0, K2[255:128]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
